// File: rtl/partida_pkg.sv
// Shared definitions for the match controller: state codes, illegal-state
// debug code, default parameters and the end-of-game rule.
package partida_pkg;

    localparam int unsigned N_JOGADORES_PADRAO    = 8;
    localparam int unsigned TIMEOUT_CICLOS_PADRAO = 0;
    localparam int unsigned W_CONTADOR            = 32;
    localparam int unsigned W_ESTADO              = 5;
    localparam int unsigned W_CONTAGEM_MAX        = 6;

    localparam logic [W_ESTADO-1:0] CODIGO_ERRO = 5'b11111;

    typedef enum logic [W_ESTADO-1:0] {
        INICIAL           = 5'd0,
        RESETA_TUDO       = 5'd1,
        PREPARA_JOGO      = 5'd2,
        ARMAZENA_JOGO     = 5'd3,
        PREPARA_NOITE     = 5'd4,
        CHECAR_VIVO_N     = 5'd5,
        DELAY_NOITE       = 5'd6,
        TURNO_NOITE       = 5'd7,
        PROXIMO_N         = 5'd8,
        AVALIAR_NOITE     = 5'd9,
        CHECAR_FIM_N      = 5'd10,
        ANUNCIAR_MORTE    = 5'd11,
        PREPARA_DIA       = 5'd12,
        CHECAR_VIVO_D     = 5'd13,
        TURNO_DIA         = 5'd14,
        PROXIMO_D         = 5'd15,
        AVALIAR_VOTACAO   = 5'd16,
        CHECAR_FIM_D      = 5'd17,
        ANUNCIAR_EXPULSAO = 5'd18,
        FIM_JOGO          = 5'd19
    } estado_t;

    // Game ends when no werewolf is left or werewolves reach parity.
    function automatic logic fim_de_jogo(input logic [W_CONTAGEM_MAX-1:0] lobos,
                                         input logic [W_CONTAGEM_MAX-1:0] aldeoes);
        return (lobos == '0) || (lobos >= aldeoes);
    endfunction

endpackage

// File: rtl/unidade_controle_partida_if.sv
// Bundle between the match controller and its environment.
//   master: buttons + datapath status drive inputs, observe strobes.
//   slave : the controller itself.
interface unidade_controle_partida_if
    import partida_pkg::*;
#(
    parameter int unsigned N_JOGADORES = N_JOGADORES_PADRAO,
    parameter int unsigned W_JOG       = $clog2(N_JOGADORES)
);
    logic               jogar;
    logic               passa;
    logic               jogador_vivo;
    logic [W_JOG:0]     lobos_vivos;
    logic [W_JOG:0]     aldeoes_vivos;
    logic [W_JOG-1:0]   jogador_atual;
    logic               rst_global;
    logic               zera_CS;
    logic               inc_seed;
    logic               e_seed_reg;
    logic               mostra_classe;
    logic               processar_acao;
    logic               avaliar_eliminacao;
    logic               processar_voto;
    logic               avaliar_votacao;
    logic               fim_jogo;
    logic               vitoria_lobos;
    logic               timeout;
    logic [4:0]         db_estado;

    modport master (
        output jogar, passa, jogador_vivo, lobos_vivos, aldeoes_vivos,
        input  jogador_atual, rst_global, zera_CS, inc_seed, e_seed_reg,
               mostra_classe, processar_acao, avaliar_eliminacao,
               processar_voto, avaliar_votacao, fim_jogo, vitoria_lobos,
               timeout, db_estado
    );

    modport slave (
        input  jogar, passa, jogador_vivo, lobos_vivos, aldeoes_vivos,
        output jogador_atual, rst_global, zera_CS, inc_seed, e_seed_reg,
               mostra_classe, processar_acao, avaliar_eliminacao,
               processar_voto, avaliar_votacao, fim_jogo, vitoria_lobos,
               timeout, db_estado
    );

endinterface

// File: rtl/temporizador_turno.sv
// Turn timer: counts while habilita is high, clears otherwise.
//   clock, reset_n : clock and async active-low reset
//   habilita       : high while a player turn is active
//   expirou_c      : high in the cycle the count reaches TIMEOUT_CICLOS-1
// TIMEOUT_CICLOS = 0 disables the timer entirely.
module temporizador_turno
    import partida_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic clock,
    input  logic reset_n,
    input  logic habilita,
    output logic expirou_c
);

    localparam logic                  ATIVO  = (TIMEOUT_CICLOS != 0);
    localparam logic [W_CONTADOR-1:0] LIMITE = W_CONTADOR'(TIMEOUT_CICLOS - 1);

    logic [W_CONTADOR-1:0] cnt_q;
    logic [W_CONTADOR-1:0] cnt_d;

    // Expiry also clears the count so a new turn always starts from zero.
    always_comb begin
        expirou_c = ATIVO && habilita && (cnt_q == LIMITE);
        cnt_d     = cnt_q + W_CONTADOR'(1);
        if (!ATIVO || !habilita || expirou_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/unidade_controle_partida.sv
// Match controller for the werewolf game: seed capture, then alternating
// night and day rounds over N_JOGADORES slots, skipping dead players, with
// end-of-game detection and optional turn auto-pass.
//   clock, reset_n : clock and async active-low reset
//   bus (slave)    : jogar/passa buttons, alive flag and alive counts in;
//                    player index, datapath strobes, winner, timeout and
//                    debug state code out.
module unidade_controle_partida
    import partida_pkg::*;
#(
    parameter int unsigned N_JOGADORES    = N_JOGADORES_PADRAO,
    parameter int unsigned W_JOG          = $clog2(N_JOGADORES),
    parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic                      clock,
    input  logic                      reset_n,
    unidade_controle_partida_if.slave bus
);

    localparam logic [W_JOG-1:0] ULTIMO = W_JOG'(N_JOGADORES - 1);

    estado_t          state_q,     state_d;
    logic [W_JOG-1:0] jogador_q,   jogador_d;
    logic             vitoria_q,   vitoria_d;
    logic             timeout_q,   timeout_d;

    logic em_turno_c;
    logic expira_c;
    logic ultimo_c;
    logic avanca_c;
    logic fim_c;

    assign em_turno_c = (state_q == TURNO_NOITE) || (state_q == TURNO_DIA);
    assign ultimo_c   = (jogador_q == ULTIMO);
    assign avanca_c   = bus.passa || expira_c;
    assign fim_c      = fim_de_jogo(W_CONTAGEM_MAX'(bus.lobos_vivos),
                                    W_CONTAGEM_MAX'(bus.aldeoes_vivos));

    temporizador_turno #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_temporizador (
        .clock     (clock),
        .reset_n   (reset_n),
        .habilita  (em_turno_c),
        .expirou_c (expira_c)
    );

    // Next state, player index, winner latch and timeout pulse.
    always_comb begin
        state_d   = state_q;
        jogador_d = jogador_q;
        vitoria_d = vitoria_q;
        // A coinciding passa takes precedence, so no pulse is reported.
        timeout_d = expira_c && !bus.passa;

        case (state_q)
            INICIAL:       if (bus.jogar) state_d = RESETA_TUDO;
            RESETA_TUDO:   state_d = PREPARA_JOGO;
            PREPARA_JOGO:  if (bus.passa) state_d = ARMAZENA_JOGO;
            ARMAZENA_JOGO: state_d = PREPARA_NOITE;
            PREPARA_NOITE: begin
                jogador_d = '0;
                state_d   = CHECAR_VIVO_N;
            end
            CHECAR_VIVO_N: begin
                if (bus.jogador_vivo) state_d = DELAY_NOITE;
                else if (ultimo_c)    state_d = AVALIAR_NOITE;
                else                  state_d = PROXIMO_N;
            end
            DELAY_NOITE:   if (bus.passa) state_d = TURNO_NOITE;
            TURNO_NOITE: begin
                if (avanca_c) state_d = ultimo_c ? AVALIAR_NOITE : PROXIMO_N;
            end
            PROXIMO_N: begin
                jogador_d = jogador_q + W_JOG'(1);
                state_d   = CHECAR_VIVO_N;
            end
            AVALIAR_NOITE: state_d = CHECAR_FIM_N;
            CHECAR_FIM_N: begin
                if (fim_c) begin
                    vitoria_d = (bus.lobos_vivos != '0);
                    state_d   = FIM_JOGO;
                end else begin
                    state_d   = ANUNCIAR_MORTE;
                end
            end
            ANUNCIAR_MORTE: if (bus.passa) state_d = PREPARA_DIA;
            PREPARA_DIA: begin
                jogador_d = '0;
                state_d   = CHECAR_VIVO_D;
            end
            CHECAR_VIVO_D: begin
                if (bus.jogador_vivo) state_d = TURNO_DIA;
                else if (ultimo_c)    state_d = AVALIAR_VOTACAO;
                else                  state_d = PROXIMO_D;
            end
            TURNO_DIA: begin
                if (avanca_c) state_d = ultimo_c ? AVALIAR_VOTACAO : PROXIMO_D;
            end
            PROXIMO_D: begin
                jogador_d = jogador_q + W_JOG'(1);
                state_d   = CHECAR_VIVO_D;
            end
            AVALIAR_VOTACAO: state_d = CHECAR_FIM_D;
            CHECAR_FIM_D: begin
                if (fim_c) begin
                    vitoria_d = (bus.lobos_vivos != '0);
                    state_d   = FIM_JOGO;
                end else begin
                    state_d   = ANUNCIAR_EXPULSAO;
                end
            end
            ANUNCIAR_EXPULSAO: if (bus.passa) state_d = PREPARA_NOITE;
            FIM_JOGO:          if (bus.jogar) state_d = RESETA_TUDO;
            default:           state_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= INICIAL;
            jogador_q <= '0;
            vitoria_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            jogador_q <= jogador_d;
            vitoria_q <= vitoria_d;
            timeout_q <= timeout_d;
        end
    end

    // Moore decode of the registered state.
    assign bus.jogador_atual      = jogador_q;
    assign bus.rst_global         = (state_q == INICIAL) || (state_q == RESETA_TUDO);
    assign bus.zera_CS            = (state_q == INICIAL) || (state_q == RESETA_TUDO);
    assign bus.inc_seed           = (state_q == PREPARA_JOGO);
    assign bus.e_seed_reg         = (state_q == ARMAZENA_JOGO);
    assign bus.mostra_classe      = (state_q == TURNO_NOITE);
    assign bus.processar_acao     = (state_q == TURNO_NOITE);
    assign bus.avaliar_eliminacao = (state_q == AVALIAR_NOITE);
    assign bus.processar_voto     = (state_q == TURNO_DIA);
    assign bus.avaliar_votacao    = (state_q == AVALIAR_VOTACAO);
    assign bus.fim_jogo           = (state_q == FIM_JOGO);
    assign bus.vitoria_lobos      = vitoria_q;
    assign bus.timeout            = timeout_q;
    assign bus.db_estado          = (state_q > FIM_JOGO) ? CODIGO_ERRO : 5'(state_q);

endmodule
